pipe_adder: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor built from ripple slices of full-adder cells.
- Splits a WIDTH-bit operation into STAGES slices; one slice is resolved per clock, and the carry is registered between slices.
- Uses a valid/ready handshake on both sides. Accepts one operation per cycle and produces carry-out and signed-overflow flags.
- Serves as the arithmetic primitive for wider datapaths where a single-cycle WIDTH-bit ripple chain misses timing.

---
 rtl/pipe_adder_pkg.sv | 24 ++
 rtl/adder_slice.sv | 46 ++++
 rtl/pipe_adder.sv | 179 +++++++++++++++++
 tb/tb_pipe_adder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg
//   Shared types and helpers for the pipelined adder/subtractor.
//   - op_e            : operation select (add / subtract)
//   - DEF_WIDTH       : default operand width
//   - DEF_STAGES      : default pipeline depth
//   - signed_overflow : two's-complement overflow from the MSB carries
package pipe_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  // Signed overflow happens when the carry into the sign bit differs
  // from the carry out of it.
  function automatic logic signed_overflow(input logic carry_in_msb,
                                           input logic carry_out_msb);
    return carry_in_msb ^ carry_out_msb;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice
//   Combinational CHUNK-bit ripple adder built from full-adder cells in
//   generate/propagate form.
//   Ports:
//     a, b   in  CHUNK  slice operands
//     cin    in  1      carry into bit 0
//     sum    out CHUNK  slice sum
//     cout   out 1      carry out of the slice MSB
//     c_msb  out 1      carry into the slice MSB (for overflow detection)
module adder_slice
  import pipe_adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] g;

  assign p = a ^ b;
  assign g = a & b;

  // The carry is walked bit by bit in a block-local variable so the
  // chain stays a single combinational process.
  always_comb begin
    logic c;
    c     = cin;
    sum   = '0;
    c_msb = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = p[i] ^ c;
      if (i == CHUNK - 1) begin
        c_msb = c;
      end
      c = g[i] | (p[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder
//   Pipelined two's-complement adder/subtractor. A WIDTH-bit operation is
//   split into STAGES slices of CHUNK = WIDTH/STAGES bits; one slice is
//   resolved per clock with the carry registered between slices.
//   Optional feature macro: PIPE_ADDER_ZERO_EN adds output z (s == 0).
//   Ports:
//     clk        in  1      clock, rising edge
//     rst        in  1      synchronous active-high reset
//     in_valid   in  1      operation presented
//     in_ready   out 1      operation can be accepted this cycle
//     a, b       in  WIDTH  operands
//     cin        in  1      carry-in (ignored when subtracting)
//     sub        in  1      0: a+b+cin, 1: a-b
//     out_valid  out 1      result present
//     out_ready  in  1      consumer accepts result
//     s          out WIDTH  sum/difference
//     cout       out 1      carry out of MSB (sub: 1 = no borrow)
//     ovf        out 1      signed overflow
//     z          out 1      result is zero (PIPE_ADDER_ZERO_EN only)
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
`ifdef PIPE_ADDER_ZERO_EN
  ,
  output logic             z
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             adv;
  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             ovf_nxt;
  logic             ovf_q;

  // The whole pipeline moves as one; it only freezes when a finished
  // result is sitting at the output and nobody is taking it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is a + ~b + 1, so the operand inversion and forced carry
  // are folded in before the first slice.
  assign op    = op_e'(sub);
  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign c_eff = (op == OP_SUB) ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO     = k * CHUNK;
    localparam int REM_IN = WIDTH - LO;

    logic [REM_IN-1:0]   op_a;
    logic [REM_IN-1:0]   op_b;
    logic                c_in;
    logic                v_in;
    logic [CHUNK-1:0]    sl_sum;
    logic                sl_cout;
    logic [LO+CHUNK-1:0] nxt_sum;
    logic                v_q;
    logic                c_q;
    logic [LO+CHUNK-1:0] sum_q;

    // Stage 0 is fed straight from the input port; later stages take the
    // operand bits the previous stage has not consumed yet.
    if (k == 0) begin : g_head
      assign op_a    = a;
      assign op_b    = b_eff;
      assign c_in    = c_eff;
      assign v_in    = in_valid;
      assign nxt_sum = sl_sum;
    end else begin : g_body
      assign op_a    = g_stage[k-1].g_mid.rem_a_q;
      assign op_b    = g_stage[k-1].g_mid.rem_b_q;
      assign c_in    = g_stage[k-1].c_q;
      assign v_in    = g_stage[k-1].v_q;
      assign nxt_sum = {sl_sum, g_stage[k-1].sum_q};
    end

    // Only the last slice's MSB carry matters, for overflow.
    if (k == STAGES - 1) begin : g_tail
      logic cmsb;

      adder_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (op_a[CHUNK-1:0]),
        .b     (op_b[CHUNK-1:0]),
        .cin   (c_in),
        .sum   (sl_sum),
        .cout  (sl_cout),
        .c_msb (cmsb)
      );

      assign ovf_nxt = signed_overflow(cmsb, sl_cout);
    end else begin : g_mid
      logic                    cmsb_unused;
      logic [REM_IN-CHUNK-1:0] rem_a_q;
      logic [REM_IN-CHUNK-1:0] rem_b_q;

      adder_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (op_a[CHUNK-1:0]),
        .b     (op_b[CHUNK-1:0]),
        .cin   (c_in),
        .sum   (sl_sum),
        .cout  (sl_cout),
        .c_msb (cmsb_unused)
      );

      // Operand bits still waiting for a later slice.
      always_ff @(posedge clk) begin
        if (rst) begin
          rem_a_q <= '0;
          rem_b_q <= '0;
        end else if (adv) begin
          rem_a_q <= op_a[REM_IN-1:CHUNK];
          rem_b_q <= op_b[REM_IN-1:CHUNK];
        end
      end
    end

    // Bubbles shift like real operations; their data is simply ignored.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        c_q   <= sl_cout;
        sum_q <= nxt_sum;
      end
    end
  end

  // Overflow flag is produced alongside the last slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_nxt;
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign s         = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = ovf_q;

`ifdef PIPE_ADDER_ZERO_EN
  logic z_q;

  // Zero detect looks at the complete sum as it enters the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= 1'b0;
    end else if (adv) begin
      z_q <= (g_stage[STAGES-1].nxt_sum == '0);
    end
  end

  assign z = z_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder
//   Directed self-checking bench for pipe_adder (WIDTH=16, STAGES=4).
module tb_pipe_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;
`ifdef PIPE_ADDER_ZERO_EN
  logic        z;
`endif

  int errors = 0;
  int checks = 0;

  // Back-to-back vectors with hand-computed results
  logic [15:0] bb_a   [8] = '{16'h0001, 16'h0FFF, 16'h1234, 16'hFFFF,
                              16'h0005, 16'h8000, 16'h1000, 16'h00F0};
  logic [15:0] bb_b   [8] = '{16'h0001, 16'h0001, 16'h4321, 16'hFFFF,
                              16'h0003, 16'h8000, 16'h2000, 16'h0F0F};
  logic        bb_cin [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        bb_sub [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] bb_s   [8] = '{16'h0002, 16'h1000, 16'h5555, 16'hFFFE,
                              16'h0002, 16'h0000, 16'hF000, 16'h1000};
  logic        bb_c   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
`ifdef PIPE_ADDER_ZERO_EN
    ,
    .z         (z)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operation into an empty pipeline, returns the latency in
  // cycles and the flags seen when out_valid first rises.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tcin, input logic tsub,
                        output int lat, output logic [15:0] os,
                        output logic oc, output logic oo, output logic oz);
    a = ta; b = tb_v; cin = tcin; sub = tsub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    os = s; oc = cout; oo = ovf;
`ifdef PIPE_ADDER_ZERO_EN
    oz = z;
`else
    oz = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, s, cout, ovf} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got valid=%b s=%h cout=%b ovf=%b expected all 0",
               out_valid, s, cout, ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
`ifdef PIPE_ADDER_ZERO_EN
    checks++;
    if (z !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_z: got %b expected 0", z);
    end
`endif
  endtask

  task automatic test_add();
    int lat; logic [15:0] rs; logic rc, ro, rz;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, rs, rc, ro, rz);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("[TB] FAIL add_latency: got %0d expected 4", lat);
    end
    checks++;
    if ({rs, rc, ro} !== {16'h0100, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL add_carry_chain: got s=%h cout=%b ovf=%b expected s=0100 cout=0 ovf=0",
               rs, rc, ro);
    end
    run_op(16'h1234, 16'h1111, 1'b1, 1'b0, lat, rs, rc, ro, rz);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("[TB] FAIL add_cin_latency: got %0d expected 4", lat);
    end
    checks++;
    if ({rs, rc, ro} !== {16'h2346, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL add_cin: got s=%h cout=%b ovf=%b expected s=2346 cout=0 ovf=0",
               rs, rc, ro);
    end
  endtask

  task automatic test_overflow();
    int lat; logic [15:0] rs; logic rc, ro, rz;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, rs, rc, ro, rz);
    checks++;
    if ({rs, rc, ro} !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL wrap_unsigned: got s=%h cout=%b ovf=%b expected s=0000 cout=1 ovf=0",
               rs, rc, ro);
    end
`ifdef PIPE_ADDER_ZERO_EN
    checks++;
    if (rz !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_flag: got %b expected 1", rz);
    end
`endif
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, rs, rc, ro, rz);
    checks++;
    if ({rs, rc, ro} !== {16'h8000, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL signed_ovf_add: got s=%h cout=%b ovf=%b expected s=8000 cout=0 ovf=1",
               rs, rc, ro);
    end
`ifdef PIPE_ADDER_ZERO_EN
    checks++;
    if (rz !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nonzero_flag: got %b expected 0", rz);
    end
`endif
  endtask

  task automatic test_sub();
    int lat; logic [15:0] rs; logic rc, ro, rz;
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, lat, rs, rc, ro, rz);
    checks++;
    if ({rs, rc, ro} !== {16'h7FFF, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL sub_ovf: got s=%h cout=%b ovf=%b expected s=7FFF cout=1 ovf=1",
               rs, rc, ro);
    end
    run_op(16'h0000, 16'h0001, 1'b0, 1'b1, lat, rs, rc, ro, rz);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("[TB] FAIL sub_latency: got %0d expected 4", lat);
    end
    checks++;
    if ({rs, rc, ro} !== {16'hFFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL sub_borrow: got s=%h cout=%b ovf=%b expected s=FFFF cout=0 ovf=0",
               rs, rc, ro);
    end
  endtask

  task automatic test_back_to_back();
    int sent, recv, cyc, stall_left, extra;
    bit seen, stall_ok, hold_ok;
    logic [15:0] held;
    sent = 0; recv = 0; cyc = 0; stall_left = 0; extra = 0;
    seen = 1'b0; stall_ok = 1'b1; hold_ok = 1'b1; held = '0;
    while (recv < 8 && cyc < 60) begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        stall_left = 3;
        held = s;
      end
      out_ready = (stall_left == 0);
      if (sent < 8) begin
        a = bb_a[sent]; b = bb_b[sent]; cin = bb_cin[sent]; sub = bb_sub[sent];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        if (in_ready !== 1'b0) stall_ok = 1'b0;
        if (out_valid !== 1'b1 || s !== held) hold_ok = 1'b0;
        stall_left--;
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        checks++;
        if ({s, cout} !== {bb_s[recv], bb_c[recv]}) begin
          errors++;
          $display("[TB] FAIL b2b_result[%0d]: got s=%h cout=%b expected s=%h cout=%b",
                   recv, s, cout, bb_s[recv], bb_c[recv]);
        end
        recv++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv !== 8) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d results expected 8", recv);
    end
    checks++;
    if (seen !== 1'b1 || stall_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_stall_ready: got seen=%b ready_low=%b expected 1 1", seen, stall_ok);
    end
    checks++;
    if (hold_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_hold: got %b expected 1 (result held during stall)", hold_ok);
    end
    repeat (6) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_duplicate: got %0d extra results expected 0", extra);
    end
  endtask

  task automatic test_reset_flush();
    int lat, stale; logic [15:0] rs; logic rc, ro, rz;
    out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 16'h1000 + 16'(i); b = 16'h0200; in_valid = 1'b1;
      @(negedge clk);
    end
    // Reset together with a new operation: both flushed and dropped
    rst = 1'b1; a = 16'h4444; b = 16'h4444; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, s, cout, ovf} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL flush_state: got valid=%b s=%h cout=%b ovf=%b expected all 0",
               out_valid, s, cout, ovf);
    end
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("[TB] FAIL flush_stale: got %0d stale results expected 0", stale);
    end
    run_op(16'h0ABC, 16'h0001, 1'b0, 1'b0, lat, rs, rc, ro, rz);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("[TB] FAIL flush_latency: got %0d expected 4", lat);
    end
    checks++;
    if ({rs, rc, ro} !== {16'h0ABD, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL flush_after: got s=%h cout=%b ovf=%b expected s=0ABD cout=0 ovf=0",
               rs, rc, ro);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_back_to_back();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
